// File: rtl/pl_run_ctrl_pkg.sv
// Shared definitions for the pipelined-CPU run/step/breakpoint controller.
// Also imported by the CPU top and the debug display for state decoding.
package pl_run_ctrl_pkg;

    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned STEP_W_DEF = 8;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned INSN_W     = 32;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BRK   = 2'd3
    } run_state_e;

endpackage

// File: rtl/pl_run_ctrl_dbg_counter.sv
// Enable/clear counter that wraps modulo 2^W; clear wins over enable.
module dbg_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pl_run_ctrl.sv
// Run/step/breakpoint controller producing the CPU-wide clock enable,
// plus enabled-cycle and retired-instruction counters for debug display.
module pl_run_ctrl
    import pl_run_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic [STEP_W-1:0] step_n,
    input  logic              brk_en,
    input  logic [ADDR_W-1:0] brk_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic [INSN_W-1:0] irw,
    input  logic              clr_cnt,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic              brk_hit,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    run_state_e        r_state;
    logic [STEP_W-1:0] r_step_left;
    logic              r_skip;
    logic              r_run_q;
    logic              r_brk_hit;

    logic              w_run_rise;
    logic              w_pc_at_brk;
    logic              w_match;
    logic [STEP_W-1:0] w_nstep;
    logic              w_step_last;
    logic              w_cpu_en;
    logic              w_retire;

    assign w_run_rise  = run & ~r_run_q;
    assign w_pc_at_brk = (pc == brk_addr);
    assign w_match     = brk_en & ~r_skip & w_pc_at_brk;
    assign w_nstep     = (step_n == '0) ? STEP_W'(1) : step_n;
    assign w_step_last = (r_step_left <= STEP_W'(1));
    assign w_retire    = w_cpu_en & (irw != '0);

    // A match blocks the enable in the same cycle, so the matching PC never reaches ID.
    always_comb begin
        w_cpu_en = 1'b0;
        case (r_state)
            ST_RUN:  w_cpu_en = ~w_match;
            ST_STEP: w_cpu_en = (r_step_left != '0) & ~w_match;
            default: w_cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PAUSE;
            r_step_left <= '0;
            r_skip      <= 1'b0;
            r_run_q     <= 1'b0;
            r_brk_hit   <= 1'b0;
        end else begin
            r_run_q <= run;

            // Re-arm the breakpoint once execution has moved off its address.
            if (w_cpu_en && !w_pc_at_brk) begin
                r_skip <= 1'b0;
            end

            case (r_state)
                ST_PAUSE: begin
                    if (run) begin
                        r_state <= ST_RUN;
                    end else if (step) begin
                        r_state     <= ST_STEP;
                        r_step_left <= w_nstep;
                    end
                end
                ST_RUN: begin
                    if (w_match) begin
                        r_state   <= ST_BRK;
                        r_brk_hit <= 1'b1;
                    end else if (!run) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_STEP: begin
                    if (w_match) begin
                        r_state     <= ST_BRK;
                        r_brk_hit   <= 1'b1;
                        r_step_left <= '0;
                    end else if (run) begin
                        r_state     <= ST_RUN;
                        r_step_left <= '0;
                    end else if (w_step_last) begin
                        r_state     <= ST_PAUSE;
                        r_step_left <= '0;
                    end else begin
                        r_step_left <= r_step_left - STEP_W'(1);
                    end
                end
                ST_BRK: begin
                    if (w_run_rise) begin
                        r_state   <= ST_RUN;
                        r_skip    <= 1'b1;
                        r_brk_hit <= 1'b0;
                    end else if (step) begin
                        r_state     <= ST_STEP;
                        r_step_left <= w_nstep;
                        r_skip      <= 1'b1;
                        r_brk_hit   <= 1'b0;
                    end
                end
                default: r_state <= ST_PAUSE;
            endcase
        end
    end

    dbg_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_cpu_en),
        .i_clr (clr_cnt),
        .o_cnt (cycle_cnt)
    );

    dbg_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_retire),
        .i_clr (clr_cnt),
        .o_cnt (retire_cnt)
    );

    assign cpu_en  = w_cpu_en;
    assign state   = r_state;
    assign brk_hit = r_brk_hit;

endmodule

// File: tb/tb_pl_run_ctrl.sv
// Scenario bench for pl_run_ctrl: expectations are queued as stimulus is
// driven, bound to observed outputs at sample points, then compared per task.
module tb_pl_run_ctrl;
    import pl_run_ctrl_pkg::*;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned STEP_W = 8;

    localparam int F_ST  = 0;
    localparam int F_EN  = 1;
    localparam int F_HIT = 2;
    localparam int F_CYC = 3;
    localparam int F_RET = 4;
    localparam int F_VAR = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              step;
    logic [STEP_W-1:0] step_n;
    logic              brk_en;
    logic [31:0]       brk_addr;
    logic [31:0]       pc;
    logic [31:0]       irw;
    logic              clr_cnt;
    logic              cpu_en;
    logic [1:0]        state;
    logic              brk_hit;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  retire_cnt;

    typedef struct {
        string       name;
        int          fld;
        logic [31:0] exp;
        logic [31:0] got;
    } sb_t;

    sb_t         sb_exp[$];
    sb_t         sb_done[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] probe;

    pl_run_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .step_n     (step_n),
        .brk_en     (brk_en),
        .brk_addr   (brk_addr),
        .pc         (pc),
        .irw        (irw),
        .clr_cnt    (clr_cnt),
        .cpu_en     (cpu_en),
        .state      (state),
        .brk_hit    (brk_hit),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic exp_push(input string name, input int fld, input logic [31:0] val);
        sb_t e;
        e.name = name;
        e.fld  = fld;
        e.exp  = val;
        e.got  = 'x;
        sb_exp.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int fld);
        case (fld)
            F_ST:    return 32'(state);
            F_EN:    return 32'(cpu_en);
            F_HIT:   return 32'(brk_hit);
            F_CYC:   return cycle_cnt;
            F_RET:   return retire_cnt;
            default: return probe;
        endcase
    endfunction

    // Bind every pending expectation to the DUT output visible right now.
    task automatic collect;
        sb_t e;
        while (sb_exp.size() > 0) begin
            e     = sb_exp.pop_front();
            e.got = observe(e.fld);
            sb_done.push_back(e);
        end
    endtask

    task automatic test_reset;
        sb_t e;
        rst = 1'b1; run = 1'b0; step = 1'b0; step_n = '0; brk_en = 1'b0;
        brk_addr = '0; pc = '0; irw = '0; clr_cnt = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_push("reset_state", F_ST, 32'd0);
            exp_push("reset_cpu_en", F_EN, 32'd0);
            exp_push("reset_brk_hit", F_HIT, 32'd0);
            exp_push("reset_cycle_cnt", F_CYC, 32'd0);
            exp_push("reset_retire_cnt", F_RET, 32'd0);
            collect;
            tick;
        end
        while (sb_done.size() > 0) begin
            e = sb_done.pop_front();
            n_cmp++;
            if (e.got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, e.got, e.exp);
            end
        end
    endtask

    task automatic test_free_run;
        sb_t e;
        clr_cnt = 1'b1;
        tick;
        clr_cnt = 1'b0;
        run = 1'b1;
        tick;
        exp_push("run_state", F_ST, 32'd1);
        collect;
        for (int i = 0; i < 20; i++) begin
            irw = ((i % 5) < 3) ? 32'h0010_0093 : 32'h0;
            if (i == 19) run = 1'b0;
            exp_push("run_cpu_en", F_EN, 32'd1);
            collect;
            tick;
        end
        irw = '0;
        exp_push("run_stop_state", F_ST, 32'd0);
        exp_push("run_stop_cpu_en", F_EN, 32'd0);
        exp_push("run_cycle_cnt", F_CYC, 32'd20);
        exp_push("run_retire_cnt", F_RET, 32'd12);
        collect;
        while (sb_done.size() > 0) begin
            e = sb_done.pop_front();
            n_cmp++;
            if (e.got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, e.got, e.exp);
            end
        end
    endtask

    task automatic test_step;
        sb_t e;
        int  cnt;
        clr_cnt = 1'b1;
        tick;
        clr_cnt = 1'b0;
        step_n = STEP_W'(3);
        step = 1'b1;
        tick;
        step = 1'b0;
        exp_push("step_entry_state", F_ST, 32'd2);
        collect;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (cpu_en) cnt++;
            step = (i == 0);
            tick;
        end
        step = 1'b0;
        probe = 32'(cnt);
        exp_push("step3_enabled_cycles", F_VAR, 32'd3);
        exp_push("step3_end_state", F_ST, 32'd0);
        exp_push("step3_cycle_cnt", F_CYC, 32'd3);
        collect;
        step_n = '0;
        step = 1'b1;
        tick;
        step = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (cpu_en) cnt++;
            tick;
        end
        probe = 32'(cnt);
        exp_push("step0_enabled_cycles", F_VAR, 32'd1);
        exp_push("step0_end_state", F_ST, 32'd0);
        exp_push("step0_cycle_cnt", F_CYC, 32'd4);
        collect;
        while (sb_done.size() > 0) begin
            e = sb_done.pop_front();
            n_cmp++;
            if (e.got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, e.got, e.exp);
            end
        end
    endtask

    task automatic test_breakpoint;
        sb_t e;
        clr_cnt = 1'b1;
        tick;
        clr_cnt = 1'b0;
        brk_en = 1'b1;
        brk_addr = 32'h3010;
        pc = 32'h3000;
        run = 1'b1;
        tick;
        for (int a = 0; a < 4; a++) begin
            pc = 32'h3000 + 32'(4 * a);
            #1;
            exp_push("brk_pre_cpu_en", F_EN, 32'd1);
            collect;
            tick;
        end
        pc = 32'h3010;
        #1;
        exp_push("brk_match_cpu_en", F_EN, 32'd0);
        exp_push("brk_match_state", F_ST, 32'd1);
        collect;
        tick;
        exp_push("brk_state", F_ST, 32'd3);
        exp_push("brk_hit", F_HIT, 32'd1);
        exp_push("brk_cycle_cnt", F_CYC, 32'd4);
        collect;
        tick;
        tick;
        exp_push("brk_hold_state", F_ST, 32'd3);
        exp_push("brk_hold_cpu_en", F_EN, 32'd0);
        exp_push("brk_frozen_cycle_cnt", F_CYC, 32'd4);
        collect;
        while (sb_done.size() > 0) begin
            e = sb_done.pop_front();
            n_cmp++;
            if (e.got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, e.got, e.exp);
            end
        end
    endtask

    task automatic test_resume;
        sb_t e;
        tick;
        exp_push("resume_level_no_exit", F_ST, 32'd3);
        collect;
        run = 1'b0;
        tick;
        exp_push("resume_low_state", F_ST, 32'd3);
        collect;
        run = 1'b1;
        tick;
        exp_push("resume_state", F_ST, 32'd1);
        exp_push("resume_brk_hit_clr", F_HIT, 32'd0);
        exp_push("resume_cpu_en_at_brk", F_EN, 32'd1);
        collect;
        tick;
        exp_push("resume_no_rehalt", F_ST, 32'd1);
        exp_push("resume_still_at_brk_en", F_EN, 32'd1);
        collect;
        pc = 32'h3014;
        #1;
        exp_push("resume_next_pc_en", F_EN, 32'd1);
        collect;
        tick;
        pc = 32'h3018;
        tick;
        pc = 32'h3010;
        #1;
        exp_push("rehalt_cpu_en", F_EN, 32'd0);
        collect;
        tick;
        exp_push("rehalt_state", F_ST, 32'd3);
        exp_push("rehalt_brk_hit", F_HIT, 32'd1);
        collect;
        while (sb_done.size() > 0) begin
            e = sb_done.pop_front();
            n_cmp++;
            if (e.got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, e.got, e.exp);
            end
        end
    endtask

    task automatic test_priority_clear;
        sb_t e;
        run = 1'b0;
        tick;
        run = 1'b1;
        tick;
        pc = 32'h3000;
        tick;
        pc = 32'h3010;
        run = 1'b0;
        tick;
        exp_push("prio_brk_over_pause", F_ST, 32'd3);
        exp_push("prio_brk_hit", F_HIT, 32'd1);
        collect;

        brk_en = 1'b0;
        tick;
        run = 1'b1;
        tick;
        irw = 32'h0000_0013;
        tick;
        tick;
        clr_cnt = 1'b1;
        tick;
        clr_cnt = 1'b0;
        exp_push("clr_state", F_ST, 32'd1);
        exp_push("clr_cycle_cnt", F_CYC, 32'd0);
        exp_push("clr_retire_cnt", F_RET, 32'd0);
        collect;
        tick;
        exp_push("after_clr_cycle_cnt", F_CYC, 32'd1);
        exp_push("after_clr_retire_cnt", F_RET, 32'd1);
        collect;

        run = 1'b0;
        irw = '0;
        tick;
        step_n = STEP_W'(5);
        step = 1'b1;
        tick;
        step = 1'b0;
        exp_push("rst_step_entry_state", F_ST, 32'd2);
        exp_push("rst_step_entry_en", F_EN, 32'd1);
        collect;
        rst = 1'b1;
        tick;
        exp_push("rst_mid_step_state", F_ST, 32'd0);
        exp_push("rst_mid_step_en", F_EN, 32'd0);
        exp_push("rst_mid_step_cycle_cnt", F_CYC, 32'd0);
        collect;
        rst = 1'b0;
        tick;
        tick;
        exp_push("rst_step_aborted_state", F_ST, 32'd0);
        exp_push("rst_step_aborted_en", F_EN, 32'd0);
        exp_push("rst_step_aborted_cycle_cnt", F_CYC, 32'd0);
        collect;
        while (sb_done.size() > 0) begin
            e = sb_done.pop_front();
            n_cmp++;
            if (e.got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, e.got, e.exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_free_run;
        test_step;
        test_breakpoint;
        test_resume;
        test_priority_clear;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pl_run_ctrl.md
Name: pl_run_ctrl

Overview:
- Run/step/breakpoint controller for the 5-stage pipelined CPU.
- Generates the CPU-wide clock enable `cpu_en`. It gates PC, all pipeline registers, RF write and DM write.
- Supports free-run, N-cycle single-step, and PC breakpoint halt.
- Keeps enabled-cycle and retired-instruction counters for the debug display. It sits between the board button/switch logic and the CPU top.

Parameters:
- CNT_W, 32, width of cycle_cnt and retire_cnt.
- STEP_W, 8, width of step_n (cycles per step request).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- run  in  1  level. 1 = free-run requested.
- step  in  1  single-cycle pulse requesting one step burst.
- step_n  in  STEP_W  enabled cycles per step burst. 0 is treated as 1.
- brk_en  in  1  breakpoint enable.
- brk_addr  in  32  breakpoint PC (IF-stage address).
- pc  in  32  current IF-stage PC from CPU.
- irw  in  32  WB-stage instruction register. 0 = bubble.
- clr_cnt  in  1  pulse, clears both counters.
- cpu_en  out  1  CPU clock enable (combinational from state and pc).
- state  out  2  0=PAUSE, 1=RUN, 2=STEP, 3=BRK.
- brk_hit  out  1  sticky. Set on breakpoint halt, cleared on leaving BRK.
- cycle_cnt  out  CNT_W  count of cycles with cpu_en=1.
- retire_cnt  out  CNT_W  count of cycles with cpu_en=1 and irw!=0.

Behaviour:
- Reset (rst=1 at posedge) values:
  - state=PAUSE, cpu_en=0, brk_hit=0.
  - cycle_cnt=0, retire_cnt=0.
  - step_left=0, skip=0.
  - run_q=0 (previous run sample).
- Internal signals:
  - run_rise = run & ~run_q.
  - match = brk_en & ~skip & (pc==brk_addr).
  - nstep = (step_n==0) ? 1 : step_n.
- cpu_en:
  - RUN: equals ~match.
  - STEP: equals (step_left!=0) & ~match.
  - PAUSE, BRK: 0.
  - A breakpoint therefore stops the CPU before the matching instruction is fetched into ID.
- PAUSE transitions:
  - run=1 → RUN.
  - else step → STEP, step_left=nstep.
  - run wins if both are present.
- RUN transitions:
  - match → BRK, brk_hit=1.
  - else run=0 → PAUSE.
  - Breakpoint takes priority over run=0 in the same cycle.
- STEP transitions:
  - Each cycle with cpu_en=1: step_left decrements.
  - When step_left reaches 0 after the decrement → PAUSE.
  - match → BRK, brk_hit=1, step_left=0.
  - step pulses received while in STEP are ignored.
  - run=1 while in STEP → RUN after the current cycle; step_left is discarded.
- BRK transitions:
  - run_rise → RUN.
  - step → STEP with step_left=nstep.
  - run held high without a new rising edge does not resume.
  - Leaving BRK sets skip=1 and clears brk_hit.
- skip:
  - Cleared after the first cycle with cpu_en=1 in which pc != brk_addr.
  - This lets execution move past the breakpoint address without immediately re-triggering.
- Counters:
  - Increment on cycles with the condition above; wrap modulo 2^CNT_W.
  - clr_cnt forces both to 0 and takes priority over an increment in the same cycle.
- brk_addr or brk_en changing mid-run takes effect combinationally the same cycle.
- A reset asserted mid-step aborts the step: all state returns to reset values next edge.

Decomposition:
- Shared package/header (also usable by the CPU top and debug display):
  - State encodings: PAUSE, RUN, STEP, BRK.
  - Defaults for CNT_W and STEP_W.
- One natural sub-module, `dbg_counter`: an enable/clear/wrap counter instantiated twice, for cycle_cnt and retire_cnt.
- FSM and breakpoint compare stay in pl_run_ctrl.

Test Plan:
- Reset then idle: rst high 2 cycles, run=0, step=0 → state=0, cpu_en=0, counters 0 for 10 cycles.
- Free-run with retirement: run=1 for 20 cycles, irw nonzero on 12 of them → cycle_cnt=20, retire_cnt=12; run=0 → state=0 next edge, cpu_en=0.
- Step burst: step_n=3, one step pulse → cpu_en=1 exactly 3 cycles, then state=0; step_n=0 → exactly 1 cycle; second step pulse during burst ignored.
- Breakpoint halt: brk_en=1, brk_addr=0x3010, run=1, pc 0x3000→0x3010 → cpu_en=0 the cycle pc=0x3010, state=3, brk_hit=1, cycle_cnt frozen.
- Resume past breakpoint: from BRK, toggle run 0→1 → state=1, cpu_en=1 with pc=0x3010, no re-halt; pc advances to 0x3014; a later return to pc=0x3010 halts again.
- Priority and clear: run=0 and match in same RUN cycle → BRK (not PAUSE); clr_cnt during increment → counters 0; rst during STEP with step_left=5 → PAUSE, step_left=0.
